// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the pipeline latches.
package cpu_types_pkg;

    typedef logic [63:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/pipe_pkg.sv
// Pipeline-stage types: skid-register state encoding and its occupancy mapping.
package pipe_pkg;

    import cpu_types_pkg::*;

    localparam int unsigned PSKID_DEFAULT_WIDTH = $bits(word_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pskid_state_t;

    function automatic logic [1:0] pskid_occ(input pskid_state_t s);
        case (s)
            FULL:    pskid_occ = 2'd1;
            SKID:    pskid_occ = 2'd2;
            default: pskid_occ = 2'd0;
        endcase
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages: registered in_ready,
// hold/flush control, and a saturating counter of stalled-valid cycles.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH = PSKID_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  NOP   = '0,
    parameter int unsigned       CNTW  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occ,
    output logic [CNTW-1:0]   stall_cnt,
    output pskid_state_t      dbg_state
);

    // Handshake: a beat moves upstream->stage when in_valid & in_ready, and
    // stage->downstream when out_valid & out_ready & !hold. A valid beat stays
    // stable until it moves; in_ready depends only on registered state.

    pskid_state_t     state_q, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_ready_q;
    logic [1:0]       occ_q;
    logic             accept, pop, stalled;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : NOP;
    assign in_ready  = in_ready_q;
    assign occ       = occ_q;
    assign dbg_state = state_q;

    assign accept  = in_valid & in_ready_q;
    assign pop     = out_valid & out_ready & ~hold;
    assign stalled = out_valid & ~(out_ready & ~hold) & ~flush;

    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Flush wins over a same-cycle accept and pop.
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = FULL;
                        main_nxt  = in_data;
                    end
                end
                FULL: begin
                    if (accept && pop) begin
                        main_nxt = in_data;
                    end else if (accept) begin
                        state_nxt = SKID;
                        skid_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        state_nxt = FULL;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= EMPTY;
            main_q     <= NOP;
            skid_q     <= NOP;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != SKID);
            occ_q      <= pskid_occ(state_nxt);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pipe_skid_reg;

    localparam int unsigned     W    = 16;
    localparam int unsigned     CW   = 4;
    localparam logic [W-1:0]    NOPV = 16'hBEEF;
    localparam int              SMAX = (1 << CW) - 1;

    logic            CLK;
    logic            nRST;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;
    logic            hold;
    logic            flush;
    logic [1:0]      occ;
    logic [CW-1:0]   stall_cnt;
    pipe_pkg::pskid_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // reference: the held beats in arrival order, plus the stall counter
    logic [W-1:0] exp_q[$];
    int           stall_m;

    pipe_skid_reg #(.WIDTH(W), .NOP(NOPV), .CNTW(CW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .hold      (hold),
        .flush     (flush),
        .occ       (occ),
        .stall_cnt (stall_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference update: fewer than two held beats means the stage can accept
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exp_q.delete();
            stall_m = 0;
        end else begin
            bit can_take, take, give;
            can_take = (exp_q.size() < 2);
            take     = in_valid && can_take;
            give     = (exp_q.size() > 0) && out_ready && !hold;
            if ((exp_q.size() > 0) && !(out_ready && !hold) && !flush && stall_m < SMAX)
                stall_m = stall_m + 1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (give) void'(exp_q.pop_front());
                if (take) exp_q.push_back(in_data);
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge CLK) begin
        check("m_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        check("m_out_data",  {16'd0, out_data},  {16'd0, (exp_q.size() > 0) ? exp_q[0] : NOPV});
        check("m_in_ready",  {31'd0, in_ready},  {31'd0, exp_q.size() < 2});
        check("m_occ",       {30'd0, occ},       exp_q.size());
        check("m_stall",     {28'd0, stall_cnt}, stall_m);
    end

    // driver: called at a negedge, applies inputs, returns at the next negedge
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic h, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        hold      = h;
        flush     = f;
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {16'd0, out_data},  32'hBEEF);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_occ",       {30'd0, occ},       32'd0);
        check("rst_stall",     {28'd0, stall_cnt}, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // streaming with no backpressure: one beat per cycle, latency 1
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
            check("stream_data", {16'd0, out_data}, i);
            check("stream_occ",  {30'd0, occ},      32'd1);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("stream_drain", {31'd0, out_valid}, 32'd0);
        check("stream_stall", {28'd0, stall_cnt}, 32'd0);

        // backpressure: fill both entries, offer an extra beat that must be refused
        cycle(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        check("bp_occ2",     {30'd0, occ},      32'd2);
        check("bp_notready", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b0);
        check("bp_head_a",   {16'd0, out_data}, 32'h000A);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("bp_pop_b",    {16'd0, out_data}, 32'h000B);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("bp_empty",    {31'd0, out_valid}, 32'd0);
        check("bp_stall",    {28'd0, stall_cnt}, 32'd2);

        // hold freezes the head for three cycles
        cycle(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
            check("hold_data", {16'd0, out_data}, 32'h000C);
        end
        check("hold_stall", {28'd0, stall_cnt}, 32'd5);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("hold_release", {31'd0, out_valid}, 32'd0);

        // flush from two entries, with an offered beat and a would-be pop
        cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000D, 1'b1, 1'b0, 1'b1);
        check("flush_occ",   {30'd0, occ},      32'd0);
        check("flush_nop",   {16'd0, out_data}, 32'hBEEF);
        check("flush_stall", {28'd0, stall_cnt}, 32'd6);
        // flush from one entry while the stage could accept
        cycle(1'b1, 16'h0013, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0014, 1'b1, 1'b0, 1'b1);
        check("flush1_occ", {30'd0, occ}, 32'd0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("flush_quiet", {31'd0, out_valid}, 32'd0);

        // saturation of the stall counter
        cycle(1'b1, 16'h0021, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("sat_stall", {28'd0, stall_cnt}, 32'hF);

        // asynchronous reset in mid-cycle with two entries held
        cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        check("pre_rst_occ", {30'd0, occ}, 32'd2);
        in_valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data",  {16'd0, out_data},  32'hBEEF);
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check("arst_occ",       {30'd0, occ},       32'd0);
        check("arst_stall",     {28'd0, stall_cnt}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        cycle(1'b1, 16'h0031, 1'b1, 1'b0, 1'b0);
        check("post_rst_data", {16'd0, out_data}, 32'h0031);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("post_rst_empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_skid_reg
